// File: rtl/mux_sel_arbiter.sv
// Two-channel arbiter driving the select of the downstream 2:1 data mux.
// Round robin by default; define MUX_ARB_FIXED_PRIO_EN for fixed priority to channel a.
module mux_sel_arbiter #(
    parameter int HOLD = 4,
    parameter int CW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          done,
    output logic          sel,
    output logic          gnt_a,
    output logic          gnt_b,
    output logic          busy,
    output logic [CW-1:0] grant_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);

    state_t        state_r;
    state_t        next_state_s;
    logic [7:0]    hold_cnt_r;
    logic          last_r;          // 1'b1 = channel b served last
    logic          sel_r;
    logic          gnt_a_r;
    logic          gnt_b_r;
    logic          busy_r;
    logic [CW-1:0] grant_cnt_r;
    logic          grant_end_s;
    logic          decide_s;

    // Grant-end detection and the arbitration decision for the next edge
    always_comb begin
        grant_end_s  = 1'b0;
        next_state_s = IDLE;
        case (state_r)
            GNT_A:   grant_end_s = (hold_cnt_r == 8'd0) || done || !req_a;
            GNT_B:   grant_end_s = (hold_cnt_r == 8'd0) || done || !req_b;
            default: grant_end_s = 1'b0;
        endcase
        decide_s = (state_r == IDLE) || grant_end_s;

        if (req_a && req_b) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
            next_state_s = GNT_A;
`else
            if (last_r) begin
                next_state_s = GNT_A;
            end else begin
                next_state_s = GNT_B;
            end
`endif
        end else if (req_a) begin
            next_state_s = GNT_A;
        end else if (req_b) begin
            next_state_s = GNT_B;
        end else begin
            next_state_s = IDLE;
        end
    end

    // Arbiter state, hold counter and registered outputs; sel holds its value through IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            hold_cnt_r  <= 8'd0;
            last_r      <= 1'b1;
            sel_r       <= 1'b0;
            gnt_a_r     <= 1'b0;
            gnt_b_r     <= 1'b0;
            busy_r      <= 1'b0;
            grant_cnt_r <= '0;
        end else if (decide_s) begin
            case (next_state_s)
                GNT_A: begin
                    state_r     <= GNT_A;
                    hold_cnt_r  <= HOLD_LOAD;
                    last_r      <= 1'b0;
                    sel_r       <= 1'b0;
                    gnt_a_r     <= 1'b1;
                    gnt_b_r     <= 1'b0;
                    busy_r      <= 1'b1;
                    grant_cnt_r <= grant_cnt_r + CW'(1);
                end
                GNT_B: begin
                    state_r     <= GNT_B;
                    hold_cnt_r  <= HOLD_LOAD;
                    last_r      <= 1'b1;
                    sel_r       <= 1'b1;
                    gnt_a_r     <= 1'b0;
                    gnt_b_r     <= 1'b1;
                    busy_r      <= 1'b1;
                    grant_cnt_r <= grant_cnt_r + CW'(1);
                end
                default: begin
                    state_r <= IDLE;
                    gnt_a_r <= 1'b0;
                    gnt_b_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end else begin
            hold_cnt_r <= hold_cnt_r - 8'd1;
        end
    end

    assign sel       = sel_r;
    assign gnt_a     = gnt_a_r;
    assign gnt_b     = gnt_b_r;
    assign busy      = busy_r;
    assign grant_cnt = grant_cnt_r;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Self-checking bench for mux_sel_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-count reference model (honours MUX_ARB_FIXED_PRIO_EN).
module tb_mux_sel_arbiter;

    localparam int HOLD = 4;
    localparam int CW   = 4;

    logic          clk;
    logic          rst;
    logic          req_a;
    logic          req_b;
    logic          done;
    logic          sel;
    logic          gnt_a;
    logic          gnt_b;
    logic          busy;
    logic [CW-1:0] grant_cnt;

    int checks;
    int errors;

    // reference model: owner 0 = none, 1 = a, 2 = b
    int m_cur;
    int m_used;
    int m_last;
    int m_cnt;
    bit m_sel;

    mux_sel_arbiter #(.HOLD(HOLD), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_b     (req_b),
        .done      (done),
        .sel       (sel),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .busy      (busy),
        .grant_cnt (grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_cur  = 0;
        m_used = 0;
        m_last = 2;
        m_cnt  = 0;
        m_sel  = 1'b0;
    endtask

    task automatic model_edge(input bit ra, input bit rb, input bit dn);
        bit owner_req;
        bit decide;
        int want;
        if (m_cur != 0) m_used++;
        owner_req = (m_cur == 1) ? ra : rb;
        decide = (m_cur == 0) || (m_used >= HOLD) || dn || !owner_req;
        if (decide) begin
            if (ra && rb) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
                want = 1;
`else
                want = (m_last == 1) ? 2 : 1;
`endif
            end else if (ra) want = 1;
            else if (rb) want = 2;
            else want = 0;
            m_cur = want;
            if (want != 0) begin
                m_used = 0;
                m_last = want;
                m_cnt  = (m_cnt + 1) % (1 << CW);
                m_sel  = (want == 2);
            end
        end
    endtask

    // advance one clock edge, update the model with the inputs seen at that edge
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(req_a, req_b, done);
        #1;
    endtask

    task automatic do_reset();
        req_a = 1'b0;
        req_b = 1'b0;
        done  = 1'b0;
        rst   = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    function automatic logic [CW+3:0] model_vec();
        logic [CW-1:0] c;
        c = m_cnt[CW-1:0];
        return {m_sel, (m_cur == 1), (m_cur == 2), (m_cur != 0), c};
    endfunction

    task automatic test_reset();
        logic [CW+3:0] zero_v;
        zero_v = '0;
        do_reset();
        checks++;
        if ({sel, gnt_a, gnt_b, busy, grant_cnt} !== zero_v) begin
            errors++;
            $display("FAIL reset_state got=%h exp=%h", {sel, gnt_a, gnt_b, busy, grant_cnt}, zero_v);
        end
        req_b = 1'b1;
        tick();
        tick();
        checks++;
        if (!(sel === 1'b1 && gnt_b === 1'b1 && busy === 1'b1)) begin
            errors++;
            $display("FAIL reset_pre_gntb sel=%b gnt_b=%b busy=%b exp 1 1 1", sel, gnt_b, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({sel, gnt_a, gnt_b, busy, grant_cnt} !== zero_v) begin
            errors++;
            $display("FAIL reset_async got=%h exp=%h", {sel, gnt_a, gnt_b, busy, grant_cnt}, zero_v);
        end
        model_reset();
        req_b = 1'b0;
        #1 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({sel, gnt_a, gnt_b, busy, grant_cnt} !== zero_v) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, {sel, gnt_a, gnt_b, busy, grant_cnt}, zero_v);
            end
        end
    endtask

    task automatic test_single();
        int exp_cnt;
        do_reset();
        req_a = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp_cnt = (i - 1) / HOLD + 1;
            checks++;
            if (!(gnt_a === 1'b1 && gnt_b === 1'b0 && sel === 1'b0 && grant_cnt === CW'(exp_cnt))) begin
                errors++;
                $display("FAIL single cyc=%0d gnt_a=%b gnt_b=%b sel=%b cnt=%0d exp 1 0 0 %0d",
                         i, gnt_a, gnt_b, sel, grant_cnt, exp_cnt);
            end
        end
        checks++;
        if (grant_cnt !== CW'(3)) begin
            errors++;
            $display("FAIL single_total cnt=%0d exp=3", grant_cnt);
        end
        req_a = 1'b0;
    endtask

    task automatic test_both();
        bit exp_sel;
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
`ifdef MUX_ARB_FIXED_PRIO_EN
        for (int i = 1; i <= 3 * HOLD; i++) begin
            tick();
            checks++;
            if (!(gnt_a === 1'b1 && gnt_b === 1'b0 && sel === 1'b0)) begin
                errors++;
                $display("FAIL fixed_prio cyc=%0d gnt_a=%b gnt_b=%b sel=%b exp 1 0 0", i, gnt_a, gnt_b, sel);
            end
        end
        req_a = 1'b0;
        tick();
        checks++;
        if (!(gnt_b === 1'b1 && gnt_a === 1'b0 && sel === 1'b1)) begin
            errors++;
            $display("FAIL fixed_handover gnt_a=%b gnt_b=%b sel=%b exp 0 1 1", gnt_a, gnt_b, sel);
        end
`else
        for (int i = 1; i <= 9; i++) begin
            tick();
            exp_sel = (((i - 1) / HOLD) % 2) == 1;
            checks++;
            if (!(sel === exp_sel && gnt_a === !exp_sel && gnt_b === exp_sel && busy === 1'b1)) begin
                errors++;
                $display("FAIL both_rr cyc=%0d sel=%b gnt_a=%b gnt_b=%b busy=%b exp sel=%b",
                         i, sel, gnt_a, gnt_b, busy, exp_sel);
            end
        end
`endif
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic test_early_release();
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
`ifdef MUX_ARB_FIXED_PRIO_EN
        if (!(gnt_a === 1'b1 && sel === 1'b0 && grant_cnt === CW'(2))) begin
            errors++;
            $display("FAIL early_release gnt_a=%b sel=%b cnt=%0d exp 1 0 2", gnt_a, sel, grant_cnt);
        end
`else
        if (!(gnt_b === 1'b1 && sel === 1'b1 && grant_cnt === CW'(2))) begin
            errors++;
            $display("FAIL early_release gnt_b=%b sel=%b cnt=%0d exp 1 1 2", gnt_b, sel, grant_cnt);
        end
`endif
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic test_req_drop();
        do_reset();
        req_b = 1'b1;
        tick();
        tick();
        req_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (!(busy === 1'b0 && sel === 1'b1 && gnt_a === 1'b0 && gnt_b === 1'b0 && grant_cnt === CW'(1))) begin
                errors++;
                $display("FAIL req_drop cyc=%0d busy=%b sel=%b gnt_a=%b gnt_b=%b cnt=%0d exp 0 1 0 0 1",
                         i, busy, sel, gnt_a, gnt_b, grant_cnt);
            end
        end
    endtask

    task automatic test_random();
        logic [CW+3:0] exp_v;
        int bias;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bias  = (i / 100) % 3;
            req_a = ($urandom_range(0, 3) > bias);
            req_b = ($urandom_range(0, 3) > bias);
            done  = ($urandom_range(0, 9) == 0);
            tick();
            exp_v = model_vec();
            checks++;
            if ({sel, gnt_a, gnt_b, busy, grant_cnt} !== exp_v) begin
                errors++;
                $display("FAIL random cyc=%0d got sel/ga/gb/busy/cnt=%b%b%b%b/%0d exp=%b%b%b%b/%0d",
                         i, sel, gnt_a, gnt_b, busy, grant_cnt,
                         exp_v[CW+3], exp_v[CW+2], exp_v[CW+1], exp_v[CW], exp_v[CW-1:0]);
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
        done  = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req_a  = 1'b0;
        req_b  = 1'b0;
        done   = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_both();
        test_early_release();
        test_req_drop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
